// File: rtl/fc_hold_monitor.sv
// fc_hold_monitor: per-layer FC stall and run-cycle statistics with a sticky limit flag.
// Define FC_HOLD_MON_SATURATE_EN for saturating accumulators; the default build wraps.
module fc_hold_monitor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             layer_start,
    input  logic             layer_done,
    input  logic             abort,
    input  logic             fc_valid,
    input  logic             fc_ready,
    output logic [WIDTH-1:0] hold_count,
    output logic [WIDTH-1:0] run_cycles,
    output logic             busy,
    output logic             result_valid,
    output logic             overflow
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [WIDTH-1:0] MAX = '1;
    state_t state, state_nx;
    logic [WIDTH-1:0] acc_hold, acc_cyc, hold_nx, cyc_nx;
    logic run_ovf, lim, hold;
    assign hold = fc_valid & ~fc_ready;
`ifdef FC_HOLD_MON_SATURATE_EN
    assign hold_nx = (acc_hold == MAX) ? MAX : acc_hold + WIDTH'(hold);
    assign cyc_nx  = (acc_cyc == MAX) ? MAX : acc_cyc + WIDTH'(1);
    assign lim     = (hold_nx == MAX) | (cyc_nx == MAX);
`else
    logic cy_hold, cy_cyc;
    assign {cy_hold, hold_nx} = {1'b0, acc_hold} + (WIDTH+1)'(hold);
    assign {cy_cyc, cyc_nx}   = {1'b0, acc_cyc} + (WIDTH+1)'(1);
    assign lim = cy_hold | cy_cyc;
`endif
    assign busy = (state == RUN);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    always_comb begin
        state_nx = (state == IDLE) ? (layer_start ? RUN : IDLE) : ((abort | layer_done) ? IDLE : RUN);
    end
    // Limit flag includes the done-cycle increment; abort drops the run without publishing.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            acc_hold     <= '0;
            acc_cyc      <= '0;
            run_ovf      <= 1'b0;
            hold_count   <= '0;
            run_cycles   <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (state == IDLE) begin
                if (layer_start) begin
                    acc_hold <= '0;
                    acc_cyc  <= '0;
                    run_ovf  <= 1'b0;
                end
            end else begin
                acc_hold <= hold_nx;
                acc_cyc  <= cyc_nx;
                run_ovf  <= run_ovf | lim;
                if (layer_done && !abort) begin
                    hold_count   <= hold_nx;
                    run_cycles   <= cyc_nx;
                    overflow     <= run_ovf | lim;
                    result_valid <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_fc_hold_monitor.sv
// tb_fc_hold_monitor: table-driven vectors plus reset, limit and retrigger sequences at WIDTH=8.
module tb_fc_hold_monitor;
    logic clk = 0, reset_n = 0;
    logic layer_start = 0, layer_done = 0, abort = 0, fc_valid = 0, fc_ready = 0;
    logic [7:0] hold_count, run_cycles;
    logic busy, result_valid, overflow;
    int passed = 0, total = 0, rv_seen = 0;

    fc_hold_monitor #(.WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .layer_start(layer_start), .layer_done(layer_done),
        .abort(abort), .fc_valid(fc_valid), .fc_ready(fc_ready), .hold_count(hold_count),
        .run_cycles(run_cycles), .busy(busy), .result_valid(result_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic s, d, a, v, r;
        logic bsy, rv;
        logic [7:0] hc, rc;
        logic ov;
    } vec_t;
    vec_t tab[$];

    task automatic add(input logic s, d, a, v, r, bsy, rv, input logic [7:0] hc, rc, input logic ov);
        vec_t e;
        e.s = s; e.d = d; e.a = a; e.v = v; e.r = r;
        e.bsy = bsy; e.rv = rv; e.hc = hc; e.rc = rc; e.ov = ov;
        tab.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input logic s, d, a, v, r);
        @(negedge clk);
        layer_start = s; layer_done = d; abort = a; fc_valid = v; fc_ready = r;
        @(posedge clk);
        #1;
        if (result_valid) rv_seen++;
    endtask

    task automatic check_all(input string tag, input logic bsy, rv, input logic [7:0] hc, rc, input logic ov);
        check({tag, ".busy"}, 32'(busy), 32'(bsy));
        check({tag, ".result_valid"}, 32'(result_valid), 32'(rv));
        check({tag, ".hold_count"}, 32'(hold_count), 32'(hc));
        check({tag, ".run_cycles"}, 32'(run_cycles), 32'(rc));
        check({tag, ".overflow"}, 32'(overflow), 32'(ov));
    endtask

    initial begin
        // basic run: 10 RUN cycles, stalls on 2,4,6,8, done on 10th
        add(1,0,0,0,1, 1,0,0,0,0);
        for (int i = 1; i <= 9; i++) add(0,0,0,1,(i % 2 == 0 && i <= 8) ? 1'b0 : 1'b1, 1,0,0,0,0);
        add(0,1,0,1,1, 0,1,4,10,0);
        add(0,0,0,0,0, 0,0,4,10,0);
        // abort after 6 stalls, then abort coincident with done
        for (int k = 0; k < 2; k++) begin
            add(1,0,0,0,0, 1,0,4,10,0);
            for (int i = 0; i < 6; i++) add(0,0,0,1,0, 1,0,4,10,0);
            add(0,logic'(k),1,1,0, 0,0,4,10,0);
            add(0,0,0,0,0, 0,0,4,10,0);
        end
        // start+done in IDLE enters RUN; retrigger mid-run is ignored
        add(1,1,0,0,0, 1,0,4,10,0);
        add(1,0,0,0,0, 1,0,4,10,0);
        add(0,0,0,0,0, 1,0,4,10,0);
        add(0,1,0,1,0, 0,1,1,3,0);
        // back-to-back runs
        add(1,0,0,0,1, 1,0,1,3,0);
        add(0,0,0,1,0, 1,0,1,3,0);
        add(0,1,0,0,1, 0,1,1,2,0);
        add(1,0,0,0,1, 1,0,1,2,0);
        add(0,0,0,1,0, 1,0,1,2,0);
        add(0,0,0,1,0, 1,0,1,2,0);
        add(0,1,0,0,1, 0,1,2,3,0);
        add(0,0,0,0,0, 0,0,2,3,0);

        #12;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].s, tab[i].d, tab[i].a, tab[i].v, tab[i].r);
            check_all($sformatf("vec%0d", i), tab[i].bsy, tab[i].rv, tab[i].hc, tab[i].rc, tab[i].ov);
        end
        check("rv_pulse_count", 32'(rv_seen), 32'd4);

        // reset mid-run
        step(1,0,0,0,1);
        for (int i = 0; i < 5; i++) step(0,0,0,1,0);
        @(negedge clk);
        reset_n = 0;
        #1;
        check_all("midrun_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1;
        step(1,0,0,0,0);
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        step(0,1,0,0,0);
        check_all("after_reset_run", 0, 1, 0, 3, 0);

        // limit run: 300 stalled cycles
        step(1,0,0,0,0);
        for (int i = 1; i <= 300; i++) step(0, logic'(i == 300), 0, 1, 0);
`ifdef FC_HOLD_MON_SATURATE_EN
        check_all("limit", 0, 1, 255, 255, 1);
`else
        check_all("limit", 0, 1, 44, 44, 1);
`endif
        step(1,0,0,0,0);
        step(0,0,0,0,0);
        step(0,1,0,0,0);
        check_all("after_limit", 0, 1, 0, 2, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
